mont_digit_core: RTL

- Radix-2^PBITS Montgomery multiplier datapath, directly downstream of the multiple-table precompute stage.
- Consumes the precomputed m-multiple table (mxn) and the reduced b-multiple table (bxn).
- Walks operand a one PBITS-bit digit per cycle, LSB digit first.
- Returns res = a*b*2^-NBITS mod m using only table lookups, additions and shifts; no multipliers.

---
 rtl/mont_digit_if.sv | 26 ++
 rtl/mont_digit_core.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mont_digit_if.sv
// Request/result bundle between the table precompute stage and the Montgomery digit core.
interface mont_digit_if #(
    parameter int unsigned NBITS = 4096,
    parameter int unsigned PBITS = 1
);
    localparam int unsigned MLSIZE = 1 << PBITS;

    logic                             start;
    logic [NBITS-1:0]                 a;
    logic [PBITS-1:0]                 mprime;
    logic [MLSIZE*(NBITS+PBITS)-1:0]  mxn_flat;
    logic [(MLSIZE-1)*NBITS-1:0]      bxn_flat;
    logic                             busy;
    logic                             done;
    logic [NBITS:0]                   res;

    modport master (
        output start, a, mprime, mxn_flat, bxn_flat,
        input  busy, done, res
    );

    modport slave (
        input  start, a, mprime, mxn_flat, bxn_flat,
        output busy, done, res
    );
endinterface

// File: rtl/mont_digit_core.sv
// Radix-2^PBITS Montgomery multiplier: res = a*b*2^-NBITS mod m via table lookups and adds.
// Optional MONT_LAZY_RED_EN drops the final subtract and returns res in [0, 2m).
module mont_digit_core #(
    parameter int unsigned NBITS = 4096,
    parameter int unsigned PBITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    mont_digit_if.slave bus
);
    localparam int unsigned MLSIZE = 1 << PBITS;
    localparam int unsigned ND     = NBITS / PBITS;
    localparam int unsigned EW     = NBITS + PBITS;
    localparam int unsigned SW     = NBITS + 2;
    localparam int unsigned UW     = NBITS + PBITS + 2;
    localparam int unsigned CW     = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {IDLE, LOOP, FINAL} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             busy_r, done_r, busy_nx, done_nx;
    logic             load, step;

    logic [NBITS-1:0] a_sr;
    logic [PBITS-1:0] mprime_r;
    logic [NBITS:0]   t_r, t_nx;
    logic [NBITS:0]   res_r, res_nx;

    logic [PBITS-1:0] digit, q;
    logic [NBITS-1:0] bx;
    logic [EW-1:0]    mq;
    logic [SW-1:0]    s;
    logic [UW-1:0]    u;

    // Next-state and control decode
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOOP;
                    load     = 1'b1;
                end
            end
            LOOP: begin
                step = 1'b1;
                if (cnt == CW'(ND - 1)) begin
`ifdef MONT_LAZY_RED_EN
                    state_nx = IDLE;
                    done_nx  = 1'b1;
`else
                    state_nx = FINAL;
`endif
                end
            end
            FINAL: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
        end
    end

    // One Montgomery digit step: T' = (T + d*b + q*m) / 2^PBITS
    always_comb begin
        digit = a_sr[PBITS-1:0];
        bx    = '0;
        for (int unsigned k = 1; k < MLSIZE; k++) begin
            if (digit == PBITS'(k)) bx = bus.bxn_flat[(k-1)*NBITS +: NBITS];
        end
        s = SW'(t_r) + SW'(bx);
        // q = s_lo * mprime mod 2^PBITS, built from shifted partial products
        q = '0;
        for (int unsigned i = 0; i < PBITS; i++) begin
            if (s[i]) q = q + PBITS'(mprime_r << i);
        end
        mq = '0;
        for (int unsigned k = 1; k < MLSIZE; k++) begin
            if (q == PBITS'(k)) mq = bus.mxn_flat[(k-1)*EW +: EW];
        end
        u    = UW'(s) + UW'(mq);
        t_nx = u[PBITS +: NBITS+1];
    end

`ifdef MONT_LAZY_RED_EN
    assign res_nx = t_nx;
`else
    // Entry 1 of the m-multiple table is m itself
    logic [NBITS:0] m_ext;
    assign m_ext  = {1'b0, bus.mxn_flat[NBITS-1:0]};
    assign res_nx = (t_r >= m_ext) ? (t_r - m_ext) : t_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            mprime_r <= '0;
            t_r      <= '0;
            cnt      <= '0;
            res_r    <= '0;
        end else begin
            if (load) begin
                a_sr     <= bus.a;
                mprime_r <= bus.mprime;
                t_r      <= '0;
                cnt      <= '0;
            end else if (step) begin
                a_sr <= a_sr >> PBITS;
                t_r  <= t_nx;
                cnt  <= cnt + CW'(1);
            end
            if (done_nx) res_r <= res_nx;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.res  = res_r;

    // Low bits of u are zero by construction; top entry k=MLSIZE is never selected
    logic unused_bits;
    assign unused_bits = ^{u[PBITS-1:0], u[UW-1], bus.mxn_flat[MLSIZE*EW-1 -: EW]};

endmodule
